// File: rtl/key_state_tracker.sv
// PS/2 key state tracker: synchronises the keycode window, debounces it and keeps held-key flags.
// Optional KEY_ARROWS_EN: arrow codes 0x6B/0x74/0x75 also drive the left/right/jump flags.
module key_state_tracker #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] keycode,
  output logic        left,
  output logic        right,
  output logic        jump,
  output logic        jump_req
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    COMMIT
  } state_t;

  localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);

  logic [15:0] sync1, sync2;
  logic [15:0] cand, accepted;
  logic [3:0]  cnt;
  state_t      state;
  logic        h_a, h_d, h_w, h_sp;
  logic        is_make;
  logic        jump_next;

  assign is_make   = (cand[15:8] != 8'hF0);
  assign jump_next = h_w | h_sp;

  // Two-flop synchroniser; only sync2 is ever looked at.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= keycode;
      sync2 <= sync1;
    end
  end

  // NOTE: state, counter and flags are all updated with <= so every branch sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cand     <= '0;
      accepted <= '0;
      cnt      <= '0;
      h_a      <= 1'b0;
      h_d      <= 1'b0;
      h_w      <= 1'b0;
      h_sp     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sync2 != accepted) begin
            cand  <= sync2;
            cnt   <= 4'd1;
            // A single-cycle filter is already satisfied by the first sample.
            state <= (STABLE_N == 4'd1) ? COMMIT : SETTLE;
          end
        end
        SETTLE: begin
          if (sync2 == cand) begin
            cnt <= cnt + 4'd1;
            if (cnt + 4'd1 == STABLE_N) state <= COMMIT;
          end else if (sync2 == accepted) begin
            state <= IDLE;
          end else begin
            cand <= sync2;
            cnt  <= 4'd1;
          end
        end
        COMMIT: begin
          accepted <= cand;
          state    <= IDLE;
          if (cand[7:0] == 8'hAA) begin
            // Keyboard self-test completion: nothing can still be held.
            h_a  <= 1'b0;
            h_d  <= 1'b0;
            h_w  <= 1'b0;
            h_sp <= 1'b0;
          end else begin
            case (cand[7:0])
              8'h1C: h_a  <= is_make;
              8'h23: h_d  <= is_make;
              8'h1D: h_w  <= is_make;
              8'h29: h_sp <= is_make;
`ifdef KEY_ARROWS_EN
              8'h6B: h_a  <= is_make;
              8'h74: h_d  <= is_make;
              8'h75: h_w  <= is_make;
`endif
              default: ;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered outputs; jump_req fires on the cycle the registered jump rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left     <= 1'b0;
      right    <= 1'b0;
      jump     <= 1'b0;
      jump_req <= 1'b0;
    end else begin
      left     <= h_a & ~h_d;
      right    <= h_d & ~h_a;
      jump     <= jump_next;
      jump_req <= jump_next & ~jump;
    end
  end

endmodule

// File: tb/tb_key_state_tracker.sv
// Self-checking bench for key_state_tracker: directed scenarios plus random keycode segments
// compared against an event-level model of the held keys.
module tb_key_state_tracker;

  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] keycode;
  logic        left, right, jump, jump_req;

  int checks   = 0;
  int failures = 0;

  // Reference model: accepted code and held keys.
  logic [15:0] m_acc;
  bit          m_a, m_d, m_w, m_sp;

  key_state_tracker #(.STABLE_CYCLES(STABLE)) dut (
    .clk      (clk),
    .rst      (rst),
    .keycode  (keycode),
    .left     (left),
    .right    (right),
    .jump     (jump),
    .jump_req (jump_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] m_out();
    return {m_a && !m_d, m_d && !m_a, m_w || m_sp};
  endfunction

  function automatic void m_clear();
    m_a = 0; m_d = 0; m_w = 0; m_sp = 0;
  endfunction

  function automatic void m_event(input logic [15:0] code);
    bit mk;
    mk = (code[15:8] != 8'hF0);
    m_acc = code;
    if (code[7:0] == 8'hAA) m_clear();
    else begin
      case (code[7:0])
        8'h1C: m_a  = mk;
        8'h23: m_d  = mk;
        8'h1D: m_w  = mk;
        8'h29: m_sp = mk;
`ifdef KEY_ARROWS_EN
        8'h6B: m_a  = mk;
        8'h74: m_d  = mk;
        8'h75: m_w  = mk;
`endif
        default: ;
      endcase
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds val on the pins for len cycles. Segments shorter than STABLE are glitches;
  // longer ones (>= STABLE+5) commit if they differ from the accepted code.
  task automatic segment(input logic [15:0] val, input int len, input string tag);
    logic [2:0] old_o, new_o;
    bit         evt, old_j;
    int         exp_pulse;
    int         pulses;
    pulses    = 0;
    exp_pulse = 0;
    keycode   = val;
    old_o     = m_out();
    old_j     = m_w || m_sp;
    evt       = (len >= STABLE) && (val != m_acc);
    if (evt) begin
      m_event(val);
      exp_pulse = (!old_j && (m_w || m_sp)) ? 1 : 0;
    end
    new_o = m_out();
    for (int k = 1; k <= len; k++) begin
      step();
      pulses += int'(jump_req);
      if (evt && k == STABLE + 3)
        check($sformatf("%s_pre", tag), {left, right, jump}, old_o);
      if (evt && k == STABLE + 4) begin
        check($sformatf("%s_latency", tag), {left, right, jump}, new_o);
        check($sformatf("%s_pulse_at", tag), jump_req, exp_pulse);
      end
    end
    check($sformatf("%s_end", tag), {left, right, jump}, new_o);
    check($sformatf("%s_pulses", tag), pulses, exp_pulse);
  endtask

  task automatic apply_reset(input logic [15:0] val);
    keycode = val;
    rst = 1'b1;
    #1;
    check("rst_async_out", {left, right, jump, jump_req}, 4'b0000);
    m_clear();
    m_acc = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  localparam int LONG = STABLE + 8;

  logic [15:0] pool [19] = '{
    16'h001C, 16'h0023, 16'h001D, 16'h0029, 16'hF01C, 16'hF023, 16'hF01D,
    16'hF029, 16'h1C23, 16'h00AA, 16'h0055, 16'hF055, 16'hE06B, 16'hF06B,
    16'h0074, 16'hF074, 16'h0075, 16'hF075, 16'h0000
  };

  initial begin
    logic [15:0] prev, val;
    int len;
    bit exp_arrow;

    rst     = 1'b1;
    keycode = 16'h0000;
    m_clear();
    m_acc = '0;
    step();
    step();
    check("reset_outputs", {left, right, jump, jump_req}, 4'b0000);
    rst = 1'b0;

    // Short glitch must not commit; returning to the accepted value leaves things quiet.
    segment(16'h001C, 2, "glitch");
    segment(16'h0000, LONG, "glitch_back");

    segment(16'h001C, LONG, "make_a");
    check("make_a_right", right, 1'b0);
    segment(16'h1C23, LONG, "both_dirs");
    segment(16'hF01C, LONG, "break_a");
    segment(16'h0029, LONG, "space");
    segment(16'h291D, LONG, "w_with_space");
    segment(16'h291D, LONG, "typematic");

    // BAT clears held keys.
    apply_reset(16'h0000);
    segment(16'h001C, LONG, "left_before_bat");
    segment(16'h00AA, LONG, "bat");
    check("bat_all_zero", {left, right, jump, jump_req}, 4'b0000);

    segment(16'hE06B, LONG, "arrow");
`ifdef KEY_ARROWS_EN
    exp_arrow = 1'b1;
`else
    exp_arrow = 1'b0;
`endif
    check("arrow_left", left, exp_arrow);

    // Reset landing mid-SETTLE and mid-COMMIT discards the pending event.
    foreach (pool[i]) begin
      if (i < 2) begin
        apply_reset(16'h0000);
        keycode = 16'h001C;
        for (int k = 0; k < ((i == 0) ? 4 : STABLE + 2); k++) step();
        apply_reset(16'h0000);
        segment(16'h0000, LONG, (i == 0) ? "rst_in_settle" : "rst_in_commit");
      end
    end

    // A non-zero code present across reset release is a fresh event.
    apply_reset(16'h0029);
    segment(16'h0029, LONG, "code_across_reset");

    prev = keycode;
    for (int n = 0; n < 60; n++) begin
      do val = pool[$urandom_range(18, 0)]; while (val == prev);
      if ($urandom_range(99, 0) < 30) begin
        len = int'($urandom_range(STABLE - 1, 1));
      end else begin
        len = int'($urandom_range(STABLE + 10, STABLE + 5));
        if ($urandom_range(99, 0) < 15 && m_acc != prev) val = m_acc;
      end
      segment(val, len, $sformatf("rand%0d", n));
      prev = val;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
